// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin mux scheduler: FSM state codes,
// default sizing and the requester-index width helper.
package rr_mux_pkg;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping N-1 -> 0, returned as one-hot grant plus binary index.
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin N:1 scheduler feeding a one-entry registered output stage.
// Define RR_MUX_BURST_EN to hold the grant on one requester until req_last.
module rr_mux_scheduler
    import rr_mux_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_id,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int unsigned IW = id_width(N);

    logic          can_load;
    logic          load;
    logic          win_found;
    logic          win_last;
    logic [N-1:0]  pick_req;
    logic [N-1:0]  win_grant;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] win_next;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_nxt;
    logic [W-1:0]  win_data;

`ifdef RR_MUX_BURST_EN
    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [IW-1:0] lock_id;
    logic [IW-1:0] lock_id_nxt;
`else
    logic          unused_last;
    assign unused_last = ^req_last;
`endif

    // While a burst is open only the locked requester is eligible.
    always_comb begin
        pick_req = req_valid;
`ifdef RR_MUX_BURST_EN
        if (state == ST_LOCKED) begin
            pick_req = req_valid & (N'(1) << lock_id);
        end
`endif
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .found (win_found),
        .idx   (win_idx)
    );

    assign can_load  = !out_valid || out_ready;
    assign load      = can_load && win_found;
    assign req_ready = can_load ? win_grant : '0;
    assign win_data  = req_data[win_idx*W +: W];
    assign win_next  = (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);

`ifdef RR_MUX_BURST_EN
    assign win_last = req_last[win_idx];
`else
    assign win_last = 1'b0;
`endif

    // Pointer and burst-lock next state; pointer moves only on a closing load.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
`ifdef RR_MUX_BURST_EN
        state_nxt   = state;
        lock_id_nxt = lock_id;
        if (load) begin
            if (win_last) begin
                state_nxt  = ST_IDLE;
                rr_ptr_nxt = win_next;
            end else begin
                state_nxt   = ST_LOCKED;
                lock_id_nxt = win_idx;
            end
        end
`else
        if (load) begin
            rr_ptr_nxt = win_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
`ifdef RR_MUX_BURST_EN
            state   <= ST_IDLE;
            lock_id <= '0;
`endif
        end else begin
            rr_ptr  <= rr_ptr_nxt;
`ifdef RR_MUX_BURST_EN
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
`endif
        end
    end

    // One-entry output register; a load in the same cycle as a drain replaces the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_id    <= win_idx;
            out_last  <= win_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Scoreboard bench for rr_mux_scheduler; burst scenarios run when RR_MUX_BURST_EN is defined.
module tb_rr_mux_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
`ifdef RR_MUX_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
    } word_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_last;
    logic           out_ready = 1'b0;

    word_t sb[$];
    word_t exp_w;
    word_t got_w;
    int    checks   = 0;
    int    failures = 0;

    rr_mux_scheduler #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic last);
        exp_w.id   = 2'(id);
        exp_w.data = d;
        exp_w.last = last & BURST;
        sb.push_back(exp_w);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++;
        if (out_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", out_id); end
        checks++;
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        req_last  = '1;
        req_data[2*W +: W] = 8'hA5;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        push(2, 8'hA5, 1'b1);
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            failures++; $display("FAIL single_valid: got %b want 1", out_valid);
        end else begin
            exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
            if (got_w !== exp_w) begin failures++; $display("FAIL single_word: got %h want %h", got_w, exp_w); end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_fairness();
        do_reset();
        out_ready = 1'b1;
        req_last  = '1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(i * 17);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                failures++; $display("FAIL fair_ready%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            push(k % 4, 8'((k % 4) * 17), 1'b1);
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL fair_valid%0d: got %b want 1", k, out_valid);
            end else begin
                exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
                if (got_w !== exp_w) begin failures++; $display("FAIL fair_word%0d: got %h want %h", k, got_w, exp_w); end
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        req_last  = '1;
        for (int i = 0; i < 3; i++) req_data[i*W +: W] = 8'h40 + 8'(i);
        req_data[3*W +: W] = 8'h33;
        req_valid = 4'b1000;
        #1;
        push(3, 8'h33, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_first_valid: got %b want 1", out_valid);
        end else begin
            exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
            if (got_w !== exp_w) begin failures++; $display("FAIL bp_first_word: got %h want %h", got_w, exp_w); end
        end
        out_ready = 1'b0;
        req_valid = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d: got %b want 0000", k, req_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 || out_id !== 2'd3) begin
                failures++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d want v=1 d=33 id=3", k, out_valid, out_data, out_id);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_ready: got %b want 0001", req_ready); end
        push(0, 8'h40, 1'b1);
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_release_valid: got %b want 1", out_valid);
        end else begin
            exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
            if (got_w !== exp_w) begin failures++; $display("FAIL bp_release_word: got %h want %h", got_w, exp_w); end
        end
        tick();
    endtask

    task automatic test_pointer();
        logic [3:0] want_ready [3];
        int         want_id    [3];
        logic [3:0] vld        [3];
        do_reset();
        out_ready = 1'b1;
        req_last  = '1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'h50 + 8'(i);
        req_valid = 4'b0010;
        #1;
        push(1, 8'h51, 1'b1);
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL ptr_seed_valid: got %b want 1", out_valid);
        end else begin
            exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
            if (got_w !== exp_w) begin failures++; $display("FAIL ptr_seed_word: got %h want %h", got_w, exp_w); end
        end
        repeat (3) tick();
        // rr_ptr=2: 3 then 0 win; after idle cycles the pointer sits at 1.
        vld[0] = 4'b1001; want_ready[0] = 4'b1000; want_id[0] = 3;
        vld[1] = 4'b1001; want_ready[1] = 4'b0001; want_id[1] = 0;
        vld[2] = 4'b1111; want_ready[2] = 4'b0010; want_id[2] = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                req_valid = '0;
                repeat (3) tick();
            end
            req_valid = vld[k];
            #1;
            checks++;
            if (req_ready !== want_ready[k]) begin
                failures++; $display("FAIL ptr_ready%0d: got %b want %b", k, req_ready, want_ready[k]);
            end
            push(want_id[k], 8'h50 + 8'(want_id[k]), 1'b1);
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL ptr_valid%0d: got %b want 1", k, out_valid);
            end else begin
                exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
                if (got_w !== exp_w) begin failures++; $display("FAIL ptr_word%0d: got %h want %h", k, got_w, exp_w); end
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_burst();
        logic [3:0] vld  [5];
        logic [3:0] lst  [5];
        logic [7:0] d1   [5];
        logic [3:0] rdy  [5];
        int         wid  [5];
        do_reset();
        out_ready = 1'b1;
        req_data[0*W +: W] = 8'hA0;
        req_data[2*W +: W] = 8'hC0;
        // beat 2 is a one-cycle gap in req_valid[1]: must bubble, not grant 0 or 2
        vld[0] = 4'b0001; lst[0] = 4'b0101; d1[0] = 8'hB0; rdy[0] = 4'b0001; wid[0] = 0;
        vld[1] = 4'b0111; lst[1] = 4'b0101; d1[1] = 8'hB1; rdy[1] = 4'b0010; wid[1] = 1;
        vld[2] = 4'b0101; lst[2] = 4'b0101; d1[2] = 8'hB1; rdy[2] = 4'b0000; wid[2] = -1;
        vld[3] = 4'b0111; lst[3] = 4'b0101; d1[3] = 8'hB2; rdy[3] = 4'b0010; wid[3] = 1;
        vld[4] = 4'b0111; lst[4] = 4'b0111; d1[4] = 8'hB3; rdy[4] = 4'b0010; wid[4] = 1;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                req_valid = vld[k]; req_last = lst[k]; req_data[1*W +: W] = d1[k];
            end else begin
                req_last = 4'b0101;
            end
            #1;
            checks++;
            if (req_ready !== ((k < 5) ? rdy[k] : 4'b0100)) begin
                failures++; $display("FAIL burst_ready%0d: got %b want %b", k, req_ready, (k < 5) ? rdy[k] : 4'b0100);
            end
            if (k == 5) push(2, 8'hC0, 1'b1);
            else if (wid[k] >= 0) push(wid[k], (wid[k] == 0) ? 8'hA0 : d1[k], lst[k][wid[k]]);
            tick();
            checks++;
            if (k < 5 && wid[k] < 0) begin
                if (out_valid !== 1'b0) begin failures++; $display("FAIL burst_bubble: got v=%b id=%0d want v=0", out_valid, out_id); end
            end else if (out_valid !== 1'b1) begin
                failures++; $display("FAIL burst_valid%0d: got %b want 1", k, out_valid);
            end else begin
                exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
                if (got_w !== exp_w) begin failures++; $display("FAIL burst_word%0d: got %h want %h", k, got_w, exp_w); end
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        req_last  = BURST ? 4'b0000 : 4'b1111;
        req_data[1*W +: W] = 8'h61;
        req_data[2*W +: W] = 8'h77;
        req_valid = 4'b0100;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            failures++; $display("FAIL arst_load: got v=%b id=%0d want v=1 id=2", out_valid, out_id);
        end
        req_valid = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 8'h00) begin
            failures++; $display("FAIL arst_clear: got v=%b id=%0d d=%h want v=0 id=0 d=00", out_valid, out_id, out_data);
        end
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL arst_ready: got %b want 0010", req_ready); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_last  = '1;
        push(1, 8'h61, 1'b1);
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL arst_first_valid: got %b want 1", out_valid);
        end else begin
            exp_w = sb.pop_front(); got_w = '{id: out_id, data: out_data, last: out_last};
            if (got_w !== exp_w) begin failures++; $display("FAIL arst_first_word: got %h want %h", got_w, exp_w); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_pointer();
`ifdef RR_MUX_BURST_EN
        test_burst();
`endif
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_empty: got %0d entries want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_scheduler.md
# rr_mux_scheduler

Round-robin scheduler that shares one registered output channel among N requesters by driving the select of an N:1 data mux. Each requester presents a valid/ready stream; the scheduler picks one winner per cycle, loads its word into a one-entry output register, and forwards it downstream with valid/ready flow control. It sits in front of any shared sink (bus, FIFO, single-port consumer) and is the sequencing layer above the plain mux datapath.

## Interface
- N, default 4: number of requesters, 2..16.
- W, default 8: data width in bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- req_valid  in  N  per-requester valid.
- req_data  in  N*W  packed data; requester i occupies bits [i*W +: W].
- req_last  in  N  per-requester end-of-burst marker; used only with RR_MUX_BURST_EN.
- req_ready  out  N  one-hot or zero; transfer on requester i when req_valid[i] & req_ready[i].
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered data.
- out_id  out  $clog2(N)  index of the requester that produced out_data.
- out_last  out  1  registered copy of req_last of the winning beat (0 without the macro).
- out_ready  in  1  downstream accept; transfer when out_valid & out_ready.

## Operation
- Output register: loads when can_load = !out_valid | out_ready. At most one load per cycle.
- Winner: first requester with req_valid set, searching from rr_ptr upward, wrapping N-1 -> 0. No valid requester -> no winner, req_ready all 0.
- req_ready[i] = can_load & (i == winner). Combinational from req_valid, rr_ptr, state, out_valid, out_ready; no combinational path from req_data.
- On a load from requester i: out_data <= req_data[i], out_id <= i, out_last <= req_last[i] (macro on) or 0, out_valid <= 1, rr_ptr <= (i+1) mod N.
- On drain without load: out_valid <= 0; out_data/out_id/out_last hold.
- Simultaneous drain and load: new word replaces old in the same edge, out_valid stays 1; full throughput 1 word/cycle.
- Fairness: with all N continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0,...; no requester waits more than N-1 grants.
- Requester dropping valid before being granted: permitted; no state change.
- Reset values: out_valid 0, out_data 0, out_id 0, out_last 0, rr_ptr 0, state IDLE. Reset mid-transfer discards the held word; no replay.

## Timing
- Latency: word accepted at edge t is on out_data with out_valid=1 immediately after edge t (visible cycle t+1).
- out_data/out_id/out_last stable while out_valid & !out_ready.
- req_ready may depend combinationally on out_ready (one gate level via can_load).
- rr_ptr updates only on a load, never on idle cycles.

## Configuration
- RR_MUX_BURST_EN defined: FSM with states IDLE and LOCKED. Load with req_last[i]=0 -> LOCKED on i; in LOCKED only requester i may win, others see req_ready 0 even if valid; locked requester not valid -> bubble, lock held. Load with req_last[i]=1 -> IDLE, rr_ptr <= i+1. rr_ptr does not advance on non-last beats.
- Not defined: no FSM, every beat arbitrated independently, req_last ignored, out_last constant 0.

## Structure
- Package rr_mux_pkg: state enum (IDLE, LOCKED), default N and W localparams, id width as $clog2(N) helper.
- Sub-module rr_pick: combinational round-robin priority picker (req vector, pointer -> one-hot grant, found flag, index). Data mux and output register stay in the top.

## Test plan
- Single requester: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1 -> req_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=A5, out_id=2.
- All four valid, data i*8'h11, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3, one word per cycle, no gaps.
- Backpressure: out_valid=1 with 8'h33, out_ready=0 for 5 cycles, others valid -> out_data stays 33, req_ready=0; on out_ready=1, next word loads same edge.
- rr_ptr=2, only requesters 0 and 3 valid -> 3 wins first, then 0.
- Macro on: requester 1 sends 3 beats (last on 3rd) while 0 and 2 valid -> out_id 1,1,1 then 2; a 1-cycle gap in req_valid[1] mid-burst yields a bubble, not a grant to 0 or 2.
- Reset pulse with out_valid=1 and LOCKED -> out_valid=0, out_id=0, rr_ptr=0, IDLE immediately (async); first post-reset grant goes to lowest valid index.
